decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- MIPS-32 instruction-decode pipeline stage. It combines three parts:
  - the IF/ID pipeline register;
  - the main/ALU control decoder;
  - a 32x32 register file with a per-register pending (scoreboard) bit.
- Produces operands, immediate, branch target, register indices and control signals for the execute stage.
- Detects RAW hazards on registers still awaiting writeback.

Parameters:
None (fixed MIPS-32 widths: 32-bit data, 5-bit register indices).

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
instrF  in  32  fetched instruction
pcPlus4F  in  32  PC+4 of fetched instruction
stall  in  1  external hold of IF/ID
flush  in  1  load NOP into IF/ID
wbEn  in  1  writeback enable
wbAddr  in  5  writeback register index
wbData  in  32  writeback data
data1  out  32  rs operand
data2  out  32  ALU operand B (immediate or rt)
writeDataD  out  32  rt value (store data)
signImm  out  32  sign-extended instr[15:0]
PCBranchD  out  32  branch target
RsD, RtD, RdD  out  5 each  instr[25:21], [20:16], [15:11]
RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, BranchD  out  1 each  control signals
ALUOp  out  2  main-decoder ALU class
ALUControlD  out  4  ALU function
hazardDetected  out  1  RAW hazard; also the fetch-stall request

Behaviour:
- IF/ID register (instrD, pcPlus4D), priority order at posedge:
  - reset or flush loads 0x00000000 / 0;
  - otherwise, if stall or hazardDetected, it holds;
  - otherwise it captures instrF / pcPlus4F.
- All decode outputs are combinational from IF/ID contents, the register file and the pending bits.
- Main decoder (by opcode instrD[31:26]):
  - 0x00 R-type: RegWrite=1, RegDst=1, ALUOp=10.
  - 0x23 lw: RegWrite=1, ALUSrc=1, MemToReg=1, ALUOp=00.
  - 0x2B sw: ALUSrc=1, MemWrite=1, ALUOp=00.
  - 0x04 beq: Branch=1, ALUOp=01.
  - 0x08 addi: RegWrite=1, ALUSrc=1, ALUOp=00.
  - Any other opcode: every control output is 0.
- ALUControlD:
  - ALUOp 00 gives 0010; ALUOp 01 gives 0110.
  - ALUOp 10 decodes funct: 0x20 add 0010, 0x22 sub 0110, 0x24 and 0000, 0x25 or 0001, 0x2A slt 0111.
  - An R-type with any other funct (including funct 0, so instruction 0 is a NOP) drives all controls to 0.
- signImm = {16{instr[15]}, instr[15:0]}.
- PCBranchD = pcPlus4D + (signImm << 2), computed modulo 2^32.
- data2 = ALUSrcD ? signImm : reg[rt]; writeDataD = reg[rt].
- Register file:
  - 2 asynchronous read ports, 1 write port.
  - Write happens at posedge when wbEn=1 and wbAddr != 0.
  - $0 always reads 0, is never written and is never pending.
- Pending bits:
  - Cleared at posedge for wbAddr when wbEn=1.
  - Set at posedge for the destination (RegDstD ? rd : rt) when RegWriteD=1, hazardDetected=0, stall=0, flush=0 and destination != 0.
  - If set and clear target the same register in the same cycle, set wins.
- hazardDetected (never asserted for source $0):
  - R-type and beq: pending[rs] or pending[rt].
  - sw: pending[rs] or pending[rt].
  - lw and addi: pending[rs].
  - Unknown opcodes and NOP: 0.
- While hazardDetected=1, all control outputs are forced to 0 (bubble). Data and index outputs still reflect instrD.
- Reset clears all 32 registers, all pending bits and IF/ID. After reset every output is 0.
- A reset asserted mid-operation discards any outstanding pending state.

Optional Feature:
- Macro: FORWARD_WB_EN.
- Defined: same-cycle writeback bypass.
  - If wbEn=1 and wbAddr equals a nonzero read index, that read returns wbData.
  - That register's pending bit is treated as clear for hazardDetected in that cycle.
- Undefined:
  - Reads return the stored value.
  - hazardDetected stays asserted until the cycle after the writeback edge.

Test Plan:
- Reset, then write 0x0000000A to r1 and 0x00000003 to r2 via wbEn; load 0x00221820 (add r3,r1,r2) -> data1=0xA, data2=0x3, RegWriteD=1, RegDstD=1, ALUControlD=0010, RdD=3, hazardDetected=0.
- Issue add r3 (sets pending[3]), then 0x00632022 (sub r4,r3,r3):
  - hazardDetected=1, controls 0, IF/ID holds;
  - wbEn r3=0x0D clears the hazard: same cycle with FORWARD_WB_EN, next cycle without; then data1=0xD.
- lw 0x8C25FFFC (lw r5,-4(r1)) -> signImm=0xFFFFFFFC, data2=0xFFFFFFFC, ALUSrcD=1, MemToRegD=1, ALUOp=00.
- beq 0x1022FFFF with pcPlus4=0x100 -> PCBranchD=0x000000FC, BranchD=1, ALUControlD=0110.
- Write 0x55 to r0, read r0 -> 0; opcode 0x3F -> all controls 0, hazardDetected=0.
- flush=1 -> IF/ID becomes 0 and all controls 0. Reset mid-hazard -> hazardDetected=0 and all registers read 0.

Source files
------------

// File: rtl/decode_stage.sv
// MIPS-32 instruction-decode stage: IF/ID register, main/ALU control decode,
// 32x32 register file with per-register pending bits and RAW hazard detection.
// Optional macro FORWARD_WB_EN: same-cycle writeback bypass on both read
// ports, which also hides the pending bit of the register being written.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrF,
    input  logic [31:0] pcPlus4F,
    input  logic        stall,
    input  logic        flush,
    input  logic        wbEn,
    input  logic [4:0]  wbAddr,
    input  logic [31:0] wbData,
    output logic [31:0] data1,
    output logic [31:0] data2,
    output logic [31:0] writeDataD,
    output logic [31:0] signImm,
    output logic [31:0] PCBranchD,
    output logic [4:0]  RsD,
    output logic [4:0]  RtD,
    output logic [4:0]  RdD,
    output logic        RegWriteD,
    output logic        MemToRegD,
    output logic        MemWriteD,
    output logic        ALUSrcD,
    output logic        RegDstD,
    output logic        BranchD,
    output logic [1:0]  ALUOp,
    output logic [3:0]  ALUControlD,
    output logic        hazardDetected
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] pend_q, pend_d;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, dest;
    logic        rw, m2r, mw, asrc, rdst, br;
    logic [1:0]  aop;
    logic [3:0]  actl;
    logic        known, need_rt;
    logic        fwd_rs, fwd_rt, busy_rs, busy_rt;
    logic [31:0] rd1, rd2;

    assign opcode = instr_q[31:26];
    assign funct  = instr_q[5:0];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];

    // Main decoder plus ALU-control decode; unrecognised encodings decode to all-zero controls
    always_comb begin
        rw = 1'b0; m2r = 1'b0; mw = 1'b0; asrc = 1'b0; rdst = 1'b0; br = 1'b0;
        aop = 2'b00; actl = 4'b0000; known = 1'b0; need_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                known   = 1'b1;
                need_rt = 1'b1;
                case (funct)
                    6'h20:   actl = 4'b0010;
                    6'h22:   actl = 4'b0110;
                    6'h24:   actl = 4'b0000;
                    6'h25:   actl = 4'b0001;
                    6'h2A:   actl = 4'b0111;
                    default: known = 1'b0;
                endcase
                rw   = known;
                rdst = known;
                aop  = known ? 2'b10 : 2'b00;
            end
            OP_LW:   begin known = 1'b1; rw = 1'b1; asrc = 1'b1; m2r = 1'b1; actl = 4'b0010; end
            OP_SW:   begin known = 1'b1; need_rt = 1'b1; asrc = 1'b1; mw = 1'b1; actl = 4'b0010; end
            OP_BEQ:  begin known = 1'b1; need_rt = 1'b1; br = 1'b1; aop = 2'b01; actl = 4'b0110; end
            OP_ADDI: begin known = 1'b1; rw = 1'b1; asrc = 1'b1; actl = 4'b0010; end
            default: ;
        endcase
    end

`ifdef FORWARD_WB_EN
    assign fwd_rs = wbEn && (wbAddr == rs) && (rs != 5'd0);
    assign fwd_rt = wbEn && (wbAddr == rt) && (rt != 5'd0);
`else
    assign fwd_rs = 1'b0;
    assign fwd_rt = 1'b0;
`endif

    // $0 is never written, so its storage is zero; the explicit test keeps reads obviously 0
    assign rd1 = (rs == 5'd0) ? 32'd0 : (fwd_rs ? wbData : regs_q[rs]);
    assign rd2 = (rt == 5'd0) ? 32'd0 : (fwd_rt ? wbData : regs_q[rt]);

    // pend_q[0] is held at 0, so source $0 never raises a hazard
    assign busy_rs = pend_q[rs] && !fwd_rs;
    assign busy_rt = pend_q[rt] && !fwd_rt;
    assign hazardDetected = known && (busy_rs || (need_rt && busy_rt));

    // Bubble: controls are zeroed while the instruction waits on a pending source
    assign RegWriteD   = rw   && !hazardDetected;
    assign MemToRegD   = m2r  && !hazardDetected;
    assign MemWriteD   = mw   && !hazardDetected;
    assign ALUSrcD     = asrc && !hazardDetected;
    assign RegDstD     = rdst && !hazardDetected;
    assign BranchD     = br   && !hazardDetected;
    assign ALUOp       = hazardDetected ? 2'b00   : aop;
    assign ALUControlD = hazardDetected ? 4'b0000 : actl;

    assign RsD        = rs;
    assign RtD        = rt;
    assign RdD        = rd;
    assign signImm    = {{16{instr_q[15]}}, instr_q[15:0]};
    assign PCBranchD  = pc4_q + {signImm[29:0], 2'b00};
    assign data1      = rd1;
    assign writeDataD = rd2;
    assign data2      = ALUSrcD ? signImm : rd2;
    assign dest       = RegDstD ? rd : rt;

    // Next-state for IF/ID, register file and scoreboard (set beats clear on the same register)
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        regs_d  = regs_q;
        pend_d  = pend_q;
        if (flush) begin
            instr_d = 32'd0;
            pc4_d   = 32'd0;
        end else if (!(stall || hazardDetected)) begin
            instr_d = instrF;
            pc4_d   = pcPlus4F;
        end
        if (wbEn) begin
            pend_d[wbAddr] = 1'b0;
            if (wbAddr != 5'd0)
                regs_d[wbAddr] = wbData;
        end
        if (RegWriteD && !stall && !flush && (dest != 5'd0))
            pend_d[dest] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // State registers; reset discards registers, scoreboard and the IF/ID contents
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= 32'd0;
            pc4_q   <= 32'd0;
            pend_q  <= 32'd0;
            regs_q  <= '{default: 32'd0};
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            pend_q  <= pend_d;
            regs_q  <= regs_d;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush, wbEn;
    logic [31:0] instrF, pcPlus4F, wbData;
    logic [4:0]  wbAddr;
    logic [31:0] data1, data2, writeDataD, signImm, PCBranchD;
    logic [4:0]  RsD, RtD, RdD;
    logic        RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, BranchD, hazardDetected;
    logic [1:0]  ALUOp;
    logic [3:0]  ALUControlD;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .instrF(instrF), .pcPlus4F(pcPlus4F),
        .stall(stall), .flush(flush), .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
        .data1(data1), .data2(data2), .writeDataD(writeDataD), .signImm(signImm),
        .PCBranchD(PCBranchD), .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .RegWriteD(RegWriteD), .MemToRegD(MemToRegD), .MemWriteD(MemWriteD),
        .ALUSrcD(ALUSrcD), .RegDstD(RegDstD), .BranchD(BranchD),
        .ALUOp(ALUOp), .ALUControlD(ALUControlD), .hazardDetected(hazardDetected)
    );

    int vectors = 0;
    int miscompares = 0;
    logic started = 1'b0;

    // Behavioural machine state
    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic [31:0] m_instr, m_pc4;

    typedef struct packed {
        logic [31:0] d1, d2, wd, simm, pcb;
        logic [4:0]  rs, rt, rd;
        logic        rw, m2r, mw, asrc, rdst, br;
        logic [1:0]  aop;
        logic [3:0]  actl;
        logic        hz;
    } exp_t;

    logic [187:0] got;
    assign got = {data1, data2, writeDataD, signImm, PCBranchD, RsD, RtD, RdD,
                  RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, BranchD,
                  ALUOp, ALUControlD, hazardDetected};

    function automatic logic [31:0] rdreg(logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef FORWARD_WB_EN
        if (wbEn && wbAddr == idx) return wbData;
`endif
        return m_regs[idx];
    endfunction

    function automatic logic busy(logic [4:0] idx);
        if (idx == 5'd0) return 1'b0;
`ifdef FORWARD_WB_EN
        if (wbEn && wbAddr == idx) return 1'b0;
`endif
        return m_pend[idx];
    endfunction

    // Control word {RegWrite,MemToReg,MemWrite,ALUSrc,RegDst,Branch,ALUOp[1:0],ALUControl[3:0]}
    function automatic exp_t model_out(logic [31:0] ins, logic [31:0] pc4);
        exp_t e;
        logic [11:0] ctl;
        logic known, needrt;
        ctl = 12'd0; known = 1'b1; needrt = 1'b0;
        case (ins[31:26])
            6'h00: begin
                needrt = 1'b1;
                case (ins[5:0])
                    6'h20: ctl = 12'b100010_10_0010;
                    6'h22: ctl = 12'b100010_10_0110;
                    6'h24: ctl = 12'b100010_10_0000;
                    6'h25: ctl = 12'b100010_10_0001;
                    6'h2A: ctl = 12'b100010_10_0111;
                    default: known = 1'b0;
                endcase
            end
            6'h23: ctl = 12'b110100_00_0010;
            6'h2B: begin ctl = 12'b001100_00_0010; needrt = 1'b1; end
            6'h04: begin ctl = 12'b000001_01_0110; needrt = 1'b1; end
            6'h08: ctl = 12'b100100_00_0010;
            default: known = 1'b0;
        endcase
        e.hz = known && (busy(ins[25:21]) || (needrt && busy(ins[20:16])));
        if (e.hz) ctl = 12'd0;
        {e.rw, e.m2r, e.mw, e.asrc, e.rdst, e.br, e.aop, e.actl} = ctl;
        e.rs   = ins[25:21];
        e.rt   = ins[20:16];
        e.rd   = ins[15:11];
        e.simm = {{16{ins[15]}}, ins[15:0]};
        e.pcb  = pc4 + e.simm * 32'd4;
        e.d1   = rdreg(e.rs);
        e.wd   = rdreg(e.rt);
        e.d2   = e.asrc ? e.simm : e.wd;
        return e;
    endfunction

    // Model state advance at each rising edge, using the inputs held across it
    initial begin
        exp_t e;
        logic [4:0] dst;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
                m_pend = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0;
            end else begin
                e = model_out(m_instr, m_pc4);
                dst = e.rdst ? e.rd : e.rt;
                if (wbEn) begin
                    m_pend[wbAddr] = 1'b0;
                    if (wbAddr != 5'd0) m_regs[wbAddr] = wbData;
                end
                if (e.rw && !stall && !flush && dst != 5'd0) m_pend[dst] = 1'b1;
                if (flush) begin
                    m_instr = 32'd0; m_pc4 = 32'd0;
                end else if (!(stall || e.hz)) begin
                    m_instr = instrF; m_pc4 = pcPlus4F;
                end
            end
            started = 1'b1;
        end
    end

    // Every-cycle comparison of the whole output bundle against the model
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                e = model_out(m_instr, m_pc4);
                vectors++;
                if (got !== 188'(e)) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got=%h exp=%h", $time, got, 188'(e));
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] x);
        vectors++;
        if (g !== x) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", nm, g, x);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ctlbits();
        return {19'd0, RegWriteD, MemToRegD, MemWriteD, ALUSrcD, RegDstD, BranchD,
                ALUOp, ALUControlD, hazardDetected};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] s, t, d;
        logic [5:0] fn;
        s = 5'($urandom_range(0, 7));
        t = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 8))
            0, 1: begin
                case ($urandom_range(0, 5))
                    0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
                    3: fn = 6'h25; 4: fn = 6'h2A; default: fn = 6'($urandom);
                endcase
                return {6'h00, s, t, d, 5'($urandom), fn};
            end
            2: return {6'h23, s, t, 16'($urandom)};
            3: return {6'h2B, s, t, 16'($urandom)};
            4: return {6'h04, s, t, 16'($urandom)};
            5, 6: return {6'h08, s, t, 16'($urandom)};
            7: return {6'($urandom), s, t, 16'($urandom)};
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        reset = 1'b1; instrF = 32'd0; pcPlus4F = 32'd0; stall = 1'b0; flush = 1'b0;
        wbEn = 1'b0; wbAddr = 5'd0; wbData = 32'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_data1", data1, 32'd0);
        chk("rst_ctl", ctlbits(), 32'd0);
        chk("rst_pcb", PCBranchD, 32'd0);

        // r1=0xA, r2=3, then add r3,r1,r2
        wbEn = 1'b1; wbAddr = 5'd1; wbData = 32'hA; tick();
        wbAddr = 5'd2; wbData = 32'h3; tick();
        wbEn = 1'b0; instrF = 32'h00221820; pcPlus4F = 32'h4; tick();
        chk("add_data1", data1, 32'hA);
        chk("add_data2", data2, 32'h3);
        chk("add_ctl", ctlbits(), 32'b1_0_0_0_1_0_10_0010_0);
        chk("add_rd", 32'(RdD), 32'd3);

        // sub r4,r3,r3 behind add r3
        instrF = 32'h00632022; tick();
        chk("sub_hz", ctlbits(), 32'd1);
        instrF = 32'd0; tick();
        chk("sub_hold_rs", 32'(RsD), 32'd3);
        chk("sub_hold_hz", 32'(hazardDetected), 32'd1);
        wbEn = 1'b1; wbAddr = 5'd3; wbData = 32'hD; instrF = 32'h00632022; #1;
`ifdef FORWARD_WB_EN
        chk("sub_fwd_hz", 32'(hazardDetected), 32'd0);
        chk("sub_fwd_d1", data1, 32'hD);
`else
        chk("sub_wb_hz", 32'(hazardDetected), 32'd1);
`endif
        tick();
        wbEn = 1'b0; #1;
        chk("sub_after_hz", 32'(hazardDetected), 32'd0);
        chk("sub_after_d1", data1, 32'hD);

        // lw r5,-4(r1)
        instrF = 32'h8C25FFFC; tick();
        chk("lw_simm", signImm, 32'hFFFFFFFC);
        chk("lw_data2", data2, 32'hFFFFFFFC);
        chk("lw_ctl", ctlbits(), 32'b1_1_0_1_0_0_00_0010_0);

        // beq r1,r2,-1 at pc+4=0x100
        instrF = 32'h1022FFFF; pcPlus4F = 32'h100; tick();
        chk("beq_pcb", PCBranchD, 32'h000000FC);
        chk("beq_ctl", ctlbits(), 32'b0_0_0_0_0_1_01_0110_0);

        // write to $0 is dropped; add r5,r0,r0 reads zeros
        instrF = 32'h00002820; wbEn = 1'b1; wbAddr = 5'd0; wbData = 32'h55; tick();
        wbEn = 1'b0; #1;
        chk("r0_data1", data1, 32'd0);
        chk("r0_data2", data2, 32'd0);

        // unknown opcode
        instrF = 32'hFC632022; tick();
        chk("bad_op_ctl", ctlbits(), 32'd0);

        // flush
        instrF = 32'h00221820; tick();
        flush = 1'b1; tick();
        flush = 1'b0; #1;
        chk("flush_instr_rs", 32'(RsD), 32'd0);
        chk("flush_ctl", ctlbits(), 32'd0);

        // reset while a hazard is outstanding
        instrF = 32'h00221820; tick();
        instrF = 32'h00632022; tick();
        chk("pre_rst_hz", 32'(hazardDetected), 32'd1);
        reset = 1'b1; tick();
        reset = 1'b0; instrF = 32'h00221820; #1;
        chk("post_rst_hz", 32'(hazardDetected), 32'd0);
        tick();
        chk("post_rst_d1", data1, 32'd0);
        chk("post_rst_d2", data2, 32'd0);

        // randomized traffic, checked by the per-cycle compare process
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 299) == 0);
            stall    = ($urandom_range(0, 9) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            wbEn     = ($urandom_range(0, 9) < 4);
            wbAddr   = 5'($urandom_range(0, 7));
            wbData   = $urandom;
            instrF   = rand_instr();
            pcPlus4F = $urandom;
            tick();
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0; wbEn = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
